// File: rtl/cache_arbiter_if.sv
// Line-fill / write-back bus between a cache-side requester and its responder.
// master drives the request and line; slave returns the completion pulse and read line.
interface cache_arbiter_if;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port L1 (I/D) to single L2 arbiter: one transaction in flight, round-robin on
// contention, every output driven from a register.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no transaction; choose a pending port and latch its request
//   GRANT_I | I-cache request presented to L2, waiting for l2.resp
//   GRANT_D | D-cache request presented to L2, waiting for l2.resp
//   RESP    | one-cycle completion pulse to the granted port
module cache_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  i_arb,
  cache_arbiter_if.slave  d_arb,
  cache_arbiter_if.master l2
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t       state;
  port_t        last_grant;
  logic         l2_read_q;
  logic         l2_write_q;
  logic [15:0]  l2_address_q;
  logic [127:0] l2_wdata_q;
  logic [127:0] rdata_q;
  logic         i_resp_q;
  logic         d_resp_q;

  logic i_pend;
  logic d_pend;
  logic pick_d;

  assign i_pend = i_arb.read | i_arb.write;
  assign d_pend = d_arb.read | d_arb.write;
  // D wins when alone, or on contention when I was served last.
  assign pick_d = d_pend & (~i_pend | (last_grant == PORT_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= PORT_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= 16'h0000;
      l2_wdata_q   <= 128'd0;
      rdata_q      <= 128'd0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          // Read and write together is illegal; write takes priority.
          if (pick_d) begin
            l2_address_q <= d_arb.address;
            l2_wdata_q   <= d_arb.wdata;
            l2_write_q   <= d_arb.write;
            l2_read_q    <= d_arb.read & ~d_arb.write;
            last_grant   <= PORT_D;
            state        <= GRANT_D;
          end else if (i_pend) begin
            l2_address_q <= i_arb.address;
            l2_wdata_q   <= i_arb.wdata;
            l2_write_q   <= i_arb.write;
            l2_read_q    <= i_arb.read & ~i_arb.write;
            last_grant   <= PORT_I;
            state        <= GRANT_I;
          end
        end
        GRANT_I, GRANT_D: begin
          if (l2.resp) begin
            rdata_q    <= l2.rdata;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            i_resp_q   <= (state == GRANT_I);
            d_resp_q   <= (state == GRANT_D);
            state      <= RESP;
          end
        end
        RESP: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign l2.read     = l2_read_q;
  assign l2.write    = l2_write_q;
  assign l2.address  = l2_address_q;
  assign l2.wdata    = l2_wdata_q;
  assign i_arb.resp  = i_resp_q;
  assign i_arb.rdata = rdata_q;
  assign d_arb.resp  = d_resp_q;
  assign d_arb.rdata = rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single reads/writes, contention order,
// mid-grant input changes, asynchronous reset and stray L2 responses.
module tb_cache_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cache_arbiter_if i_bus ();
  cache_arbiter_if d_bus ();
  cache_arbiter_if l2_bus ();

  cache_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_arb (i_bus),
    .d_arb (d_bus),
    .l2    (l2_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_l2_read"}, l2_bus.read, 1'b0);
    chk1({tag, "_l2_write"}, l2_bus.write, 1'b0);
    chk16({tag, "_l2_address"}, l2_bus.address, 16'h0000);
    chk128({tag, "_l2_wdata"}, l2_bus.wdata, 128'd0);
    chk1({tag, "_i_resp"}, i_bus.resp, 1'b0);
    chk1({tag, "_d_resp"}, d_bus.resp, 1'b0);
    chk128({tag, "_i_rdata"}, i_bus.rdata, 128'd0);
    chk128({tag, "_d_rdata"}, d_bus.rdata, 128'd0);
  endtask

  localparam logic [127:0] LINE_I  = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam logic [127:0] LINE_W  = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
  localparam logic [127:0] LINE_WR = 128'hCAFEF00D_00000000_00000000_00000001;
  localparam logic [127:0] LINE_ST = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] LINE_LG = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;

  logic         exp_d [4];
  logic [127:0] rd;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.address = 16'h0; i_bus.wdata = 128'd0;
    d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.address = 16'h0; d_bus.wdata = 128'd0;
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;

    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single I read, L2 answers in cycle 3, address changes while granted.
    i_bus.read = 1'b1; i_bus.address = 16'h1230;
    chk1("i_rd_c0_l2_read", l2_bus.read, 1'b0);
    step();
    chk1("i_rd_c1_l2_read", l2_bus.read, 1'b1);
    chk16("i_rd_c1_addr", l2_bus.address, 16'h1230);
    chk1("i_rd_c1_l2_write", l2_bus.write, 1'b0);
    step();
    chk1("i_rd_c2_l2_read", l2_bus.read, 1'b1);
    i_bus.address = 16'hFFFF;
    step();
    chk1("i_rd_c3_l2_read", l2_bus.read, 1'b1);
    chk16("i_rd_c3_addr_held", l2_bus.address, 16'h1230);
    chk1("i_rd_c3_i_resp", i_bus.resp, 1'b0);
    l2_bus.resp = 1'b1; l2_bus.rdata = LINE_I;
    step();
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    i_bus.read = 1'b0; i_bus.address = 16'h0;
    chk1("i_rd_c4_i_resp", i_bus.resp, 1'b1);
    chk128("i_rd_c4_rdata", i_bus.rdata, LINE_I);
    chk1("i_rd_c4_d_resp", d_bus.resp, 1'b0);
    chk1("i_rd_c4_l2_read", l2_bus.read, 1'b0);
    step();
    chk1("i_rd_c5_i_resp", i_bus.resp, 1'b0);
    chk128("i_rd_c5_rdata_hold", i_bus.rdata, LINE_I);

    // D write-back.
    d_bus.write = 1'b1; d_bus.address = 16'h8000; d_bus.wdata = LINE_W;
    step();
    chk1("d_wr_c1_l2_write", l2_bus.write, 1'b1);
    chk1("d_wr_c1_l2_read", l2_bus.read, 1'b0);
    chk16("d_wr_c1_addr", l2_bus.address, 16'h8000);
    chk128("d_wr_c1_wdata", l2_bus.wdata, LINE_W);
    step();
    chk1("d_wr_c2_l2_write", l2_bus.write, 1'b1);
    l2_bus.resp = 1'b1; l2_bus.rdata = LINE_WR;
    step();
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    d_bus.write = 1'b0;
    chk1("d_wr_c3_d_resp", d_bus.resp, 1'b1);
    chk1("d_wr_c3_i_resp", i_bus.resp, 1'b0);
    chk1("d_wr_c3_l2_write", l2_bus.write, 1'b0);
    chk1("d_wr_c3_l2_read", l2_bus.read, 1'b0);
    chk128("d_wr_c3_rdata", d_bus.rdata, LINE_WR);
    step();
    chk1("d_wr_c4_d_resp", d_bus.resp, 1'b0);

    // Contention from reset: grants must go D, I, D, I.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    i_bus.read = 1'b1; i_bus.address = 16'h1000;
    d_bus.read = 1'b1; d_bus.address = 16'h2000;
    for (int g = 0; g < 4; g++) begin
      step();
      chk16($sformatf("rr%0d_addr", g), l2_bus.address, exp_d[g] ? 16'h2000 : 16'h1000);
      chk1($sformatf("rr%0d_l2_read", g), l2_bus.read, 1'b1);
      rd = {32'hC0DE0000 + 32'(g), 96'd0};
      l2_bus.resp = 1'b1; l2_bus.rdata = rd;
      step();
      l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
      chk1($sformatf("rr%0d_d_resp", g), d_bus.resp, exp_d[g]);
      chk1($sformatf("rr%0d_i_resp", g), i_bus.resp, ~exp_d[g]);
      chk128($sformatf("rr%0d_rdata", g), d_bus.rdata, rd);
      step();
      chk1($sformatf("rr%0d_idle_d_resp", g), d_bus.resp, 1'b0);
      chk1($sformatf("rr%0d_idle_i_resp", g), i_bus.resp, 1'b0);
      chk1($sformatf("rr%0d_idle_l2_read", g), l2_bus.read, 1'b0);
    end

    // Reset in the middle of a D read.
    i_bus.read = 1'b0;
    step();
    chk1("rst_mid_l2_read", l2_bus.read, 1'b1);
    chk16("rst_mid_addr", l2_bus.address, 16'h2000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    d_bus.read = 1'b0;
    step();
    rst_n = 1'b1;
    l2_bus.resp = 1'b1; l2_bus.rdata = LINE_ST;
    step();
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    chk1("stale_d_resp", d_bus.resp, 1'b0);
    chk1("stale_i_resp", i_bus.resp, 1'b0);
    chk128("stale_rdata", d_bus.rdata, 128'd0);
    step();
    chk1("stale2_d_resp", d_bus.resp, 1'b0);

    // Stray l2_resp in IDLE with nothing pending.
    l2_bus.resp = 1'b1; l2_bus.rdata = LINE_ST;
    step();
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    chk1("stray_i_resp", i_bus.resp, 1'b0);
    chk1("stray_d_resp", d_bus.resp, 1'b0);
    chk1("stray_l2_read", l2_bus.read, 1'b0);
    chk128("stray_rdata", i_bus.rdata, 128'd0);
    step();
    chk1("stray2_i_resp", i_bus.resp, 1'b0);

    // Contention after reset goes to D again (last_grant was cleared).
    i_bus.read = 1'b1; i_bus.address = 16'h1000;
    d_bus.read = 1'b1; d_bus.address = 16'h2000;
    step();
    chk1("post_rst_l2_read", l2_bus.read, 1'b1);
    chk16("post_rst_addr", l2_bus.address, 16'h2000);
    l2_bus.resp = 1'b1; l2_bus.rdata = LINE_LG;
    step();
    l2_bus.resp = 1'b0; l2_bus.rdata = 128'd0;
    i_bus.read = 1'b0; d_bus.read = 1'b0;
    chk1("post_rst_d_resp", d_bus.resp, 1'b1);
    chk1("post_rst_i_resp", i_bus.resp, 1'b0);
    chk128("post_rst_rdata", d_bus.rdata, LINE_LG);
    step();
    chk1("post_rst_end_d_resp", d_bus.resp, 1'b0);
    chk1("post_rst_end_l2_read", l2_bus.read, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
